stopwatch_ctrl: RTL and testbench

Stopwatch controller that sequences a four-digit BCD time count (MM:SS, 00:00–59:59) from the system clock. Built-in prescaler produces the once-per-second enable; cascaded mod-10/mod-6 digit stages advance under an IDLE/RUN/PAUSE state machine driven by pre-debounced one-cycle button pulses. A lap function freezes the displayed value while counting continues. Sits between the key-debounce block and the seven-segment display driver.

---
 rtl/stopwatch_ctrl.sv | 152 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: MM:SS BCD count (00:00-59:59) with a built-in
// one-second prescaler, IDLE/RUN/PAUSE sequencing from one-cycle button
// pulses, and a lap function that freezes the display while counting goes on.
module stopwatch_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int PW       = 26
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       lap_active,
    output logic       tick_1hz,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

    // Counts are packed as {min_hi, min_lo, sec_hi, sec_lo}.
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   live_q, live_d;
    logic [15:0]   disp_q, disp_d;
    logic          running_q, running_d;
    logic          lap_active_q, lap_active_d;
    logic          tick_q, tick_d;
    logic          overflow_q, overflow_d;

    // Next-state logic: button handling, prescaler, digit cascade and display select.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        live_d       = live_q;
        lap_active_d = lap_active_q;
        tick_d       = 1'b0;
        overflow_d   = 1'b0;

        if (clear) begin
            state_d      = IDLE;
            presc_d      = '0;
            live_d       = '0;
            lap_active_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (start_stop) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (live_q[3:0] != 4'd9) begin
                            live_d[3:0] = live_q[3:0] + 4'd1;
                        end else begin
                            live_d[3:0] = 4'd0;
                            if (live_q[7:4] != 4'd5) begin
                                live_d[7:4] = live_q[7:4] + 4'd1;
                            end else begin
                                live_d[7:4] = 4'd0;
                                if (live_q[11:8] != 4'd9) begin
                                    live_d[11:8] = live_q[11:8] + 4'd1;
                                end else begin
                                    live_d[11:8] = 4'd0;
                                    if (live_q[15:12] != 4'd5) begin
                                        live_d[15:12] = live_q[15:12] + 4'd1;
                                    end else begin
                                        live_d[15:12] = 4'd0;
                                        overflow_d    = 1'b1;
                                    end
                                end
                            end
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                    if (start_stop) begin
                        state_d = PAUSE;
                    end
                    if (lap) begin
                        lap_active_d = ~lap_active_q;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end

        // A fresh capture takes the post-edge live value; a held lap keeps the old display.
        if (!lap_active_d || !lap_active_q) begin
            disp_d = live_d;
        end else begin
            disp_d = disp_q;
        end

        running_d = (state_d == RUN);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            live_q       <= '0;
            disp_q       <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            tick_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            live_q       <= live_d;
            disp_q       <= disp_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            tick_q       <= tick_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sec_lo     = disp_q[3:0];
    assign sec_hi     = disp_q[7:4];
    assign min_lo     = disp_q[11:8];
    assign min_hi     = disp_q[15:12];
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign tick_1hz   = tick_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with a 4-cycle second.
module tb_stopwatch_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] sec_lo;
    logic [3:0] sec_hi;
    logic [3:0] min_lo;
    logic [3:0] min_hi;
    logic       running;
    logic       lap_active;
    logic       tick_1hz;
    logic       overflow;

    int assertCount;
    int failCount;

    stopwatch_ctrl #(
        .CLK_FREQ(4),
        .PW(3)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .start_stop(start_stop),
        .clear(clear),
        .lap(lap),
        .sec_lo(sec_lo),
        .sec_hi(sec_hi),
        .min_lo(min_lo),
        .min_hi(min_hi),
        .running(running),
        .lap_active(lap_active),
        .tick_1hz(tick_1hz),
        .overflow(overflow)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [15:0] displayValue();
        return {min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives the given button pulses for exactly one rising edge, then returns
    // just after that edge (on the following falling edge).
    task automatic applyStimulus(input logic ss, input logic clr, input logic lp);
        start_stop = ss;
        clear      = clr;
        lap        = lp;
        @(negedge sys_clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        int tickCount;
        int lastTick;
        logic spacingOk;
        logic pauseQuiet;

        assertCount = 0;
        failCount   = 0;
        sys_rst_n   = 1'b0;
        start_stop  = 1'b0;
        clear       = 1'b0;
        lap         = 1'b0;

        #1;
        checkOutput("reset_display", 32'(displayValue()), 32'h0000);
        checkOutput("reset_flags", {28'd0, running, lap_active, tick_1hz, overflow}, 32'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        waitCycles(2);
        checkOutput("idle_no_tick", 32'(tick_1hz), 32'd0);

        // Start, then 40 cycles: ticks at cycles 4, 8, ... 40.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_running", 32'(running), 32'd1);
        tickCount = 0;
        lastTick  = 0;
        spacingOk = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge sys_clk);
            if (tick_1hz) begin
                if (i - lastTick != 4) spacingOk = 1'b0;
                lastTick = i;
                tickCount++;
            end
        end
        checkOutput("tick_count_40", 32'(tickCount), 32'd10);
        checkOutput("tick_spacing", 32'(spacingOk), 32'd1);
        checkOutput("display_0010", 32'(displayValue()), 32'h0010);
        checkOutput("running_after_40", 32'(running), 32'd1);

        // Seconds-to-minutes carry.
        waitCycles(49 * 4);
        checkOutput("display_0059", 32'(displayValue()), 32'h0059);
        waitCycles(4);
        checkOutput("display_0100", 32'(displayValue()), 32'h0100);

        // Run to 59:59 and across the wrap.
        waitCycles(3539 * 4);
        checkOutput("display_5959", 32'(displayValue()), 32'h5959);
        waitCycles(3);
        checkOutput("pre_wrap_ovf", 32'(overflow), 32'd0);
        waitCycles(1);
        checkOutput("wrap_display", 32'(displayValue()), 32'h0000);
        checkOutput("wrap_overflow", 32'(overflow), 32'd1);
        checkOutput("wrap_tick", 32'(tick_1hz), 32'd1);
        checkOutput("wrap_running", 32'(running), 32'd1);
        waitCycles(1);
        checkOutput("ovf_one_cycle", 32'(overflow), 32'd0);
        waitCycles(3);
        checkOutput("after_wrap_0001", 32'(displayValue()), 32'h0001);

        // Pause two cycles into a second, hold 20 cycles, resume.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clear_display", 32'(displayValue()), 32'h0000);
        checkOutput("clear_running", 32'(running), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pause_running", 32'(running), 32'd0);
        pauseQuiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (tick_1hz || displayValue() != 16'h0000) pauseQuiet = 1'b0;
        end
        checkOutput("pause_quiet", 32'(pauseQuiet), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume_running", 32'(running), 32'd1);
        waitCycles(1);
        checkOutput("resume_no_tick_1", 32'(tick_1hz), 32'd0);
        waitCycles(1);
        checkOutput("resume_tick_2", 32'(tick_1hz), 32'd1);
        checkOutput("resume_display", 32'(displayValue()), 32'h0001);

        // Lap freeze and release.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("lap_pre_0005", 32'(displayValue()), 32'h0005);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lap_active_set", 32'(lap_active), 32'd1);
        checkOutput("lap_frozen_0005", 32'(displayValue()), 32'h0005);
        waitCycles(11);
        checkOutput("lap_still_0005", 32'(displayValue()), 32'h0005);
        checkOutput("lap_still_active", 32'(lap_active), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lap_release_0008", 32'(displayValue()), 32'h0008);
        checkOutput("lap_active_clr", 32'(lap_active), 32'd0);

        // Clear wins over start_stop in the same cycle.
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("clr_ss_running", 32'(running), 32'd0);
        checkOutput("clr_ss_display", 32'(displayValue()), 32'h0000);
        waitCycles(8);
        checkOutput("clr_ss_stays_idle", 32'(displayValue()), 32'h0000);

        // Lap ignored in IDLE and PAUSE.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lap_idle_ignored", 32'(lap_active), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("lap_pause_ignored", 32'(lap_active), 32'd0);
        checkOutput("lap_pause_running", 32'(running), 32'd0);

        // start_stop on a tick edge: the tick completes, then pause.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ss_tick_edge_tick", 32'(tick_1hz), 32'd1);
        checkOutput("ss_tick_edge_disp", 32'(displayValue()), 32'h0001);
        checkOutput("ss_tick_edge_run", 32'(running), 32'd0);

        // Asynchronous reset between edges.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("pre_reset_disp", 32'(displayValue()), 32'h0002);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_disp", 32'(displayValue()), 32'h0000);
        checkOutput("async_rst_run", 32'(running), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        waitCycles(6);
        checkOutput("post_reset_idle", 32'(displayValue()), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
